// File: rtl/trajectory_predictor_if.sv
// Ball-sample / prediction-result bundle between the trajectory engine and its neighbours.
// master drives samples and reads results; slave is the trajectory_predictor itself.
interface trajectory_predictor_if #(
    parameter int COORD_W = 10
);
    logic               vsync_start;
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic               busy;
    logic               predicted_valid;
    logic [COORD_W-1:0] predicted_y;
    logic               target_right;
    logic               ball_move_up;
    logic [3:0]         bounces;
    logic               timeout;

    modport master (
        output vsync_start, ball_x, ball_y,
        input  busy, predicted_valid, predicted_y, target_right, ball_move_up, bounces, timeout
    );

    modport slave (
        input  vsync_start, ball_x, ball_y,
        output busy, predicted_valid, predicted_y, target_right, ball_move_up, bounces, timeout
    );
endinterface

// File: rtl/trajectory_predictor.sv
// Per-frame ball trajectory engine: derives velocity from two vsync samples, then steps one frame
// per clock with wall reflections until the ball reaches a paddle column, reporting the intercept y.
module trajectory_predictor #(
    parameter int COORD_W   = 10,
    parameter int V_ACTIVE  = 480,
    parameter int BALL_SIZE = 8,
    parameter int LEFT_X    = 16,
    parameter int RIGHT_X   = 624,
    parameter int MAX_SPEED = 32,
    parameter int MAX_STEPS = 1023
) (
    input logic                   i_clock,
    input logic                   i_reset_n,
    trajectory_predictor_if.slave bus
);
    localparam int W      = COORD_W + 2;
    localparam int STEP_W = $clog2(MAX_STEPS + 1);

    localparam logic signed [W-1:0] ZERO    = '0;
    localparam logic signed [W-1:0] SPEED   = W'(MAX_SPEED);
    localparam logic signed [W-1:0] Y_MAX   = W'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [W-1:0] X_LEFT  = W'(LEFT_X);
    localparam logic signed [W-1:0] X_RIGHT = W'(RIGHT_X - BALL_SIZE);
    localparam logic [STEP_W-1:0]   LAST    = STEP_W'(MAX_STEPS - 1);
    localparam logic [COORD_W-1:0]  Y_MID   = COORD_W'(V_ACTIVE / 2);

    typedef enum logic [1:0] {IDLE, LOAD, STEP} state_t;

    state_t state, state_next;

    logic [COORD_W-1:0] prev_x, prev_y, cur_x, cur_y;
    logic               sample_valid;

    logic signed [W-1:0] x, y, dx, dy;
    logic [STEP_W-1:0]   steps;
    logic [3:0]          bounce_cnt;

    logic signed [W-1:0] in_dx, in_dy, x_next, y_step, y_next, dy_next;
    logic                delta_ok, start_run, wall_hit, target_hit, last_step;
    logic [3:0]          bounce_next;

    logic               pred_valid, pred_right, pred_up, pred_timeout;
    logic [COORD_W-1:0] pred_y;
    logic [3:0]         pred_bounces;

    function automatic logic signed [W-1:0] ext(input logic [COORD_W-1:0] v);
        return signed'({2'b00, v});
    endfunction

    // Velocity the incoming sample would produce; large jumps are respawns, not motion.
    assign in_dx     = ext(bus.ball_x) - ext(cur_x);
    assign in_dy     = ext(bus.ball_y) - ext(cur_y);
    assign delta_ok  = (in_dx != ZERO) && (in_dx <= SPEED) && (in_dx >= -SPEED)
                       && (in_dy <= SPEED) && (in_dy >= -SPEED);
    assign start_run = bus.vsync_start && sample_valid && delta_ok;
    assign last_step = (steps == LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        x_next   = x + dx;
        y_step   = y + dy;
        y_next   = y_step;
        dy_next  = dy;
        wall_hit = 1'b0;
        if (y_step < ZERO) begin
            y_next   = -y_step;
            dy_next  = -dy;
            wall_hit = 1'b1;
        end else if (y_step > Y_MAX) begin
            y_next   = Y_MAX + Y_MAX - y_step;
            dy_next  = -dy;
            wall_hit = 1'b1;
        end
        target_hit  = (dx < ZERO) ? (x_next <= X_LEFT) : (x_next >= X_RIGHT);
        bounce_next = (wall_hit && bounce_cnt != 4'hF) ? bounce_cnt + 4'd1 : bounce_cnt;
    end

    always_ff @(posedge i_clock) begin
        // NOTE: sequential state is written only with non-blocking assignments.
        if (!i_reset_n) state <= IDLE;
        else            state <= state_next;
    end

    // A new vsync always restarts: it either launches a fresh LOAD or abandons the run.
    always_comb begin
        state_next = state;
        if (bus.vsync_start) begin
            state_next = start_run ? LOAD : IDLE;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                LOAD:    state_next = STEP;
                STEP:    if (target_hit || last_step) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy = (state != IDLE);
    end

    // NOTE: the stepping registers are fully loaded in LOAD before any use, so they carry no reset.
    always_ff @(posedge i_clock) begin
        if (state == LOAD) begin
            x          <= ext(cur_x);
            y          <= ext(cur_y);
            dx         <= ext(cur_x) - ext(prev_x);
            dy         <= ext(cur_y) - ext(prev_y);
            steps      <= '0;
            bounce_cnt <= '0;
        end else if (state == STEP) begin
            x          <= x_next;
            y          <= y_next;
            dy         <= dy_next;
            steps      <= steps + 1'b1;
            bounce_cnt <= bounce_next;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            prev_x       <= '0;
            prev_y       <= '0;
            cur_x        <= '0;
            cur_y        <= '0;
            sample_valid <= 1'b0;
            pred_valid   <= 1'b0;
            pred_y       <= Y_MID;
            pred_right   <= 1'b0;
            pred_up      <= 1'b0;
            pred_bounces <= '0;
            pred_timeout <= 1'b0;
        end else if (bus.vsync_start) begin
            prev_x       <= cur_x;
            prev_y       <= cur_y;
            cur_x        <= bus.ball_x;
            cur_y        <= bus.ball_y;
            sample_valid <= 1'b1;
            if (sample_valid && (!delta_ok || ((in_dx > ZERO) != pred_right)))
                pred_valid <= 1'b0;
        end else if (state == STEP) begin
            if (target_hit) begin
                pred_y       <= y_next[COORD_W-1:0];
                pred_right   <= (dx > ZERO);
                pred_up      <= (dy_next < ZERO);
                pred_bounces <= bounce_next;
                pred_valid   <= 1'b1;
                pred_timeout <= 1'b0;
            end else if (last_step) begin
                pred_timeout <= 1'b1;
                pred_valid   <= 1'b0;
            end
        end
    end

    assign bus.predicted_valid = pred_valid;
    assign bus.predicted_y     = pred_y;
    assign bus.target_right    = pred_right;
    assign bus.ball_move_up    = pred_up;
    assign bus.bounces         = pred_bounces;
    assign bus.timeout         = pred_timeout;
endmodule
